// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider: op/state encodings,
// datapath widths and a magnitude helper.
package div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract the
// divisor on a widened path and keep the difference when it does not borrow.
module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;
  logic            trial_unused;

  // The shifted remainder can reach 33 bits when the divisor MSB is set,
  // so the trial carries one extra bit to keep the borrow unambiguous.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    if (!trial[XLEN+1]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

  assign trial_unused = trial[XLEN];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divide/remainder unit for RV32M, 32 steps per
// op, with a one-cycle fast path for divide-by-zero and signed overflow.
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Start,
  input  logic [1:0]      DivOp,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] DivResult
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  rem_reg, quo_reg, dvs_reg, result_reg;
  logic             rem_sel_reg, neg_q_reg, neg_r_reg;
  logic             busy_reg, done_reg;

  logic [XLEN-1:0]  rem_step, quo_step, final_quo, final_rem;
  logic             is_signed;

  div_step u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvs_reg),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  assign is_signed = (DivOp == DIV_OP_DIV) || (DivOp == DIV_OP_REM);
  assign final_quo = neg_q_reg ? -quo_step : quo_step;
  assign final_rem = neg_r_reg ? -rem_step : rem_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= DIV_IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      result_reg  <= '0;
      rem_sel_reg <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (Flush) begin
        state_reg <= DIV_IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          DIV_IDLE, DIV_DONE: begin
            state_reg <= DIV_IDLE;
            busy_reg  <= 1'b0;
            if (Start) begin
              if (SrcB == '0) begin
                result_reg <= DivOp[1] ? SrcA : '1;
                state_reg  <= DIV_DONE;
                done_reg   <= 1'b1;
              end else if (is_signed && SrcA == INT_MIN && SrcB == '1) begin
                result_reg <= DivOp[1] ? '0 : INT_MIN;
                state_reg  <= DIV_DONE;
                done_reg   <= 1'b1;
              end else begin
                rem_reg     <= '0;
                quo_reg     <= abs_val(SrcA, is_signed);
                dvs_reg     <= abs_val(SrcB, is_signed);
                cnt_reg     <= '0;
                rem_sel_reg <= DivOp[1];
                neg_q_reg   <= is_signed && (SrcA[XLEN-1] ^ SrcB[XLEN-1]);
                neg_r_reg   <= is_signed && SrcA[XLEN-1];
                state_reg   <= DIV_CALC;
                busy_reg    <= 1'b1;
              end
            end
          end
          DIV_CALC: begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + 1'b1;
            // Last step: sign-fix the freshly computed values straight into the result.
            if (cnt_reg == '1) begin
              result_reg <= rem_sel_reg ? final_rem : final_quo;
              state_reg  <= DIV_DONE;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
            end
          end
          default: begin
            state_reg <= DIV_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Busy      = busy_reg;
  assign Done      = done_reg;
  assign DivResult = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a scoreboard queue of expected results from an
// arithmetic reference, checked on Done together with latency and Busy length.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [1:0]  DivOp = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Busy, Done;
  logic [31:0] DivResult;

  logic [31:0] st_rem, st_quo, st_div, st_rem_n, st_quo_n;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  div_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Start     (Start),
    .DivOp     (DivOp),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Flush     (Flush),
    .Busy      (Busy),
    .Done      (Done),
    .DivResult (DivResult)
  );

  div_step u_ref_step (
    .rem      (st_rem),
    .quo      (st_quo),
    .divisor  (st_div),
    .rem_next (st_rem_n),
    .quo_next (st_quo_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      DIV_OP_DIV:  return 32'($signed(a) / $signed(b));
      DIV_OP_REM:  return 32'($signed(a) % $signed(b));
      DIV_OP_DIVU: return a / b;
      default:     return a % b;
    endcase
  endfunction

  // Accept happens at the edge between the two negedges; inputs are scrambled afterwards.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    DivOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    if (push) exp_q.push_back(ref_model(op, a, b));
    @(negedge clk);
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; DivOp = 2'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int cyc;
    int busy_n;
    logic [31:0] expv;
    cyc = 1; busy_n = 0;
    while (!Done && cyc < 80) begin
      if (Busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_n), (exp_lat == 1) ? 32'd0 : 32'd32);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_res"}, DivResult, expv);
    $display("txn %s result=%h expected=%h latency=%0d busy=%0d", tag, DivResult, expv, cyc, busy_n);
  endtask

  initial begin
    int done_seen;
    logic [31:0] held;

    // Reset state while reset_n is low
    #2;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_res", DivResult, 32'd0);

    // Single restoring-step sanity checks, including the 33-bit shifted case
    st_rem = 32'd0; st_quo = 32'h8000_0000; st_div = 32'd1; #1;
    check("step0_rem", st_rem_n, 32'd0);  check("step0_quo", st_quo_n, 32'd1);
    st_rem = 32'd5; st_quo = 32'd0; st_div = 32'd7; #1;
    check("step1_rem", st_rem_n, 32'd3);  check("step1_quo", st_quo_n, 32'd1);
    st_rem = 32'd3; st_quo = 32'd0; st_div = 32'd7; #1;
    check("step2_rem", st_rem_n, 32'd6);  check("step2_quo", st_quo_n, 32'd0);
    st_rem = 32'hFFFF_FFFE; st_quo = 32'h8000_0000; st_div = 32'hFFFF_FFFF; #1;
    check("step3_rem", st_rem_n, 32'hFFFF_FFFE); check("step3_quo", st_quo_n, 32'd1);

    @(negedge clk);
    reset_n = 1'b1;

    issue(DIV_OP_DIVU, 32'd100, 32'd7, 1'b1);          wait_done("divu_100_7", 33);
    issue(DIV_OP_REMU, 32'd100, 32'd7, 1'b1);          wait_done("remu_100_7", 33);
    issue(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);     wait_done("div_m100_7", 33);
    issue(DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 1'b1);     wait_done("rem_m100_7", 33);
    issue(DIV_OP_DIV, 32'd1234567, 32'hFFFF_FFFD, 1'b1); wait_done("div_pos_neg", 33);
    issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1); wait_done("divu_big", 33);

    issue(DIV_OP_DIVU, 32'd55, 32'd0, 1'b1);           wait_done("divu_by0", 1);
    @(negedge clk);
    check("done_pulse_len", {31'd0, Done}, 32'd0);
    issue(DIV_OP_REMU, 32'd55, 32'd0, 1'b1);           wait_done("remu_by0", 1);
    issue(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done("div_ovf", 1);
    issue(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done("rem_ovf", 1);

    // Flush mid-CALC: no Done, result held, then a fresh op completes normally
    held = DivResult;
    issue(DIV_OP_DIVU, 32'd1000, 32'd10, 1'b0);
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_busy", {31'd0, Busy}, 32'd0);
    check("flush_done", {31'd0, Done}, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done || Busy) done_seen++;
    end
    check("flush_no_done", 32'(done_seen), 32'd0);
    check("flush_res_held", DivResult, held);
    issue(DIV_OP_DIVU, 32'd9, 32'd3, 1'b1);            wait_done("divu_9_3", 33);

    // Back-to-back: new Start presented during the DONE cycle
    issue(DIV_OP_REMU, 32'd100, 32'd7, 1'b1);          wait_done("b2b_first", 33);
    DivOp = DIV_OP_DIVU; SrcA = 32'd81; SrcB = 32'd9; Start = 1'b1;
    exp_q.push_back(ref_model(DIV_OP_DIVU, 32'd81, 32'd9));
    @(negedge clk);
    Start = 1'b0;
    wait_done("b2b_second", 33);

    // Asynchronous reset in the middle of CALC
    issue(DIV_OP_DIV, 32'd5000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_done", {31'd0, Done}, 32'd0);
    check("arst_res", DivResult, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(DIV_OP_REM, 32'd5000, 32'hFFFF_FFFD, 1'b1);  wait_done("rem_after_rst", 33);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
